// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NCH-channel round-robin / fixed-priority arbiter feeding one registered output slot.
// Latency: 1 cycle from an accepted input word to out_valid/out_data/out_sel.
// Backpressure: an empty slot or out_ready=1 lets a new word load in the same cycle (no bubble);
//               with the slot full and out_ready=0 every in_ready is 0.
//
// Ports:
//   clk, rst_n         - clock; synchronous active-low reset
//   mode               - 0 = round-robin from ptr, 1 = fixed priority (lowest index wins)
//   in_data/in_valid   - packed per-channel data (channel i at [i*WIDTH +: WIDTH]) and requests
//   in_ready           - per-channel accept, combinational, at most one bit high
//   out_data/out_sel   - registered winning word and the index of the channel that supplied it
//   out_valid          - registered; the output slot holds a word
//   out_ready          - downstream accept
module rr_arb_mux #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic [NCH-1:0]    grant;
    logic [SELW-1:0]   gnt_idx;
    logic              gnt_any;
    logic [SELW-1:0]   cand;
    logic [WIDTH-1:0]  gnt_data;
    logic              load_en;
    logic              xfer;

    // (base + off) mod NCH. Both operands are below NCH, so a single
    // conditional subtract keeps the result in range for any NCH, which
    // is what stops ptr from ever reaching an unused code when NCH is not
    // a power of two.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= $unsigned(NCH)) begin
            s = s - $unsigned(NCH);
        end
        return s[SELW-1:0];
    endfunction

    // Arbitration: walk NCH candidates in priority order and keep the first
    // requester. Fixed priority walks 0..NCH-1; round-robin starts at ptr.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = mode ? SELW'(k) : wrap_inc(ptr_q, k);
            if (!gnt_any && in_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];

    // The slot can take a word when it is empty or being drained this cycle.
    assign load_en  = (state_q == ST_EMPTY) || out_ready;

    // Gating with rst_n keeps a requester from believing it was consumed in
    // a reset cycle, since the register update is discarded by the reset.
    assign xfer     = rst_n && load_en && gnt_any;
    assign in_ready = xfer ? grant : '0;

    // Next-state / datapath
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;

        case (state_q)
            ST_EMPTY: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !xfer) begin
                    // Drained with nothing to replace it; data/sel keep their values.
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // The pointer advances past every winner in either mode so that a
        // switch back to round-robin resumes after the last served channel.
        if (xfer) begin
            data_d = gnt_data;
            sel_d  = gnt_idx;
            ptr_d  = wrap_inc(gnt_idx, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    localparam int W = 4;
    localparam int N = 4;
    localparam int S = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [S-1:0]     out_sel;

    rr_arb_mux #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the output slot as plain integers, plus the rotating pointer.
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_sel   = 0;
    int m_ptr   = 0;

    logic [N-1:0] rdy_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Channel index the rules say should win this cycle, or -1 if none.
    function automatic int winner(input bit r, input bit md, input logic [N-1:0] v, input bit ordy);
        int ch;
        if (!r) return -1;
        if (m_valid && !ordy) return -1;
        for (int k = 0; k < N; k++) begin
            ch = md ? k : (m_ptr + k) % N;
            if (v[ch]) return ch;
        end
        return -1;
    endfunction

    // One clock: drive inputs after the falling edge, check in_ready, then
    // let the rising edge happen and check the registered outputs.
    task automatic step(input bit r, input bit md, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input bit ordy);
        int w;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst_n     = r;
        mode      = md;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        w = winner(r, md, v, ordy);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        rdy_seen = in_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (!r) begin
            m_valid = 1'b0; m_data = 0; m_sel = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = int'((d >> (w * W)) & 16'hF);
            m_sel   = w;
            m_ptr   = (w + 1) % N;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset then idle, with requests present during reset.
        step(1'b0, 1'b0, 4'b1111, 16'h4321, 1'b1);
        step(1'b0, 1'b0, 4'b1111, 16'h4321, 1'b1);
        check("rst_ready", 32'(rdy_seen), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_sel",   32'(out_sel),   32'h0);
        step(1'b1, 1'b0, 4'b0000, 16'h4321, 1'b1);
        check("idle_valid", 32'(out_valid), 32'h0);

        // Round-robin fairness, one word per cycle.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 4'b1111, 16'h4321, 1'b1);
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_data",  32'(out_data),  32'((k % 4) + 1));
            check("rr_sel",   32'(out_sel),   32'(k % 4));
        end

        // Fixed priority: ch1 always beats ch2.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 4'b0110, 16'h4321, 1'b1);
            check("fp_ready", 32'(rdy_seen), 32'h2);
            check("fp_sel",   32'(out_sel),  32'h1);
            check("fp_data",  32'(out_data), 32'h2);
        end

        // Backpressure: load A, stall three cycles, then release.
        step(1'b1, 1'b1, 4'b0001, 16'h432A, 1'b1);
        check("bp_load", 32'(out_data), 32'hA);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 4'b1111, 16'h4325, 1'b0);
            check("bp_ready", 32'(rdy_seen),  32'h0);
            check("bp_hold",  32'(out_data),  32'hA);
            check("bp_valid", 32'(out_valid), 32'h1);
        end
        step(1'b1, 1'b1, 4'b1111, 16'h4325, 1'b1);
        check("bp_next_ready", 32'(rdy_seen), 32'h1);
        check("bp_next_data",  32'(out_data), 32'h5);

        // Wrap and sparse requests: ch2 moves ptr to 3, then 0101 -> ch0, ch2.
        step(1'b1, 1'b0, 4'b0100, 16'h4321, 1'b1);
        check("wrap_pre_sel", 32'(out_sel), 32'h2);
        step(1'b1, 1'b0, 4'b0101, 16'h4321, 1'b1);
        check("wrap_ready0", 32'(rdy_seen), 32'h1);
        check("wrap_sel0",   32'(out_sel),  32'h0);
        step(1'b1, 1'b0, 4'b0101, 16'h4321, 1'b1);
        check("wrap_ready2", 32'(rdy_seen), 32'h4);
        check("wrap_sel2",   32'(out_sel),  32'h2);

        // Reset while FULL with out_sel=2: word is dropped, search restarts at 0.
        step(1'b0, 1'b0, 4'b1111, 16'h4321, 1'b0);
        check("mid_rst_ready", 32'(rdy_seen),  32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_sel",   32'(out_sel),   32'h0);
        step(1'b1, 1'b0, 4'b0000, 16'h4321, 1'b1);
        check("mid_rst_gone", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 4'b1111, 16'h4321, 1'b1);
        check("post_rst_first", 32'(rdy_seen), 32'h1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom),
                 16'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
